// File: rtl/eeprom_spi_bridge_if.sv
// Core-side request/response bundle between the uC_8bits memory port and the EEPROM bridge.
// The master drives the request; the slave holds req_ready low and answers with a one-cycle rsp_valid.
interface eeprom_spi_bridge_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/eeprom_spi_bridge.sv
// Byte read/write bridge from the core to a 25xx SPI EEPROM (WREN, WRITE, READ, RDSR polling).
// Read completes 1+48*CLK_DIV cycles after accept; the core is stalled (req_ready low) until rsp_valid.
module eeprom_spi_bridge #(
  parameter int CLK_DIV  = 4,
  parameter int CS_GAP   = 2,
  parameter int POLL_MAX = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  eeprom_spi_bridge_if.slave   bus,
  output logic                 spi_sck,
  output logic                 spi_cs_n,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);
  localparam int              GW        = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(CS_GAP - 1);
  localparam logic [7:0]      DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [9:0]      POLL_LAST = 10'(POLL_MAX - 1);

  typedef enum logic [2:0] {IDLE, WREN, GAP, XFER, POLL, RESP} state_t;

  state_t        state_q, state_d, next_q, next_d, start_st;
  logic          we_q, we_d;
  logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [23:0]   tx_q, tx_d, frame;
  logic [7:0]    rx_q, rx_d;
  logic [4:0]    bits_q, bits_d;
  logic [7:0]    div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [9:0]    poll_q, poll_d;
  logic          sck_q, sck_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          start, f_we, gap_ok;
  logic [7:0]    f_addr, f_wdata;

  assign gap_ok = (gap_q == GAP_LAST);

  always_comb begin
    state_d  = state_q;
    next_d   = next_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    bits_d   = bits_q;
    div_d    = div_q;
    gap_d    = gap_q;
    poll_d   = poll_q;
    sck_d    = sck_q;
    cs_n_d   = cs_n_q;
    mosi_d   = mosi_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    start    = 1'b0;
    start_st = next_q;
    f_we     = we_q;
    f_addr   = addr_q;
    f_wdata  = wdata_q;
    frame    = 24'h0;

    // gap_q counts cs_n-high cycles so every frame start honours CS_GAP
    if (cs_n_q && !gap_ok) gap_d = gap_q + GW'(1);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          poll_d   = 10'd0;
          f_we     = bus.req_we;
          f_addr   = bus.req_addr;
          f_wdata  = bus.req_wdata;
          next_d   = bus.req_we ? WREN : XFER;
          start_st = next_d;
          if (gap_ok) start = 1'b1;
          else        state_d = GAP;
        end
      end
      GAP: start = gap_ok;
      WREN, XFER, POLL: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], spi_miso};
          end else if (bits_q == 5'd1) begin
            cs_n_d = 1'b1;
            mosi_d = 1'b0;
            bits_d = 5'd0;
            gap_d  = '0;
            case (state_q)
              WREN: begin
                state_d = GAP;
                next_d  = XFER;
              end
              XFER: begin
                if (we_q) begin
                  state_d = GAP;
                  next_d  = POLL;
                end else begin
                  state_d = RESP;
                  rdata_d = rx_q;
                  err_d   = 1'b0;
                end
              end
              default: begin
                // rx_q now holds the RDSR status byte; bit 0 is write-in-progress
                if (!rx_q[0]) begin
                  state_d = RESP;
                  err_d   = 1'b0;
                end else if (poll_q == POLL_LAST) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                end else begin
                  poll_d  = poll_q + 10'd1;
                  state_d = GAP;
                  next_d  = POLL;
                end
              end
            endcase
          end else begin
            tx_d   = {tx_q[22:0], 1'b0};
            mosi_d = tx_q[22];
            bits_d = bits_q - 5'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start) begin
      case (start_st)
        WREN: begin
          frame  = 24'h06_0000;
          bits_d = 5'd8;
        end
        XFER: begin
          frame  = {f_we ? 8'h02 : 8'h03, f_addr, f_we ? f_wdata : 8'h00};
          bits_d = 5'd24;
        end
        default: begin
          frame  = 24'h05_0000;
          bits_d = 5'd16;
        end
      endcase
      state_d = start_st;
      tx_d    = frame;
      mosi_d  = frame[23];
      cs_n_d  = 1'b0;
      sck_d   = 1'b0;
      div_d   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      next_q  <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      tx_q    <= 24'h0;
      rx_q    <= 8'h00;
      bits_q  <= 5'd0;
      div_q   <= 8'd0;
      gap_q   <= '0;
      poll_q  <= 10'd0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bits_q  <= bits_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign spi_sck       = sck_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_mosi      = mosi_q;
endmodule

// File: tb/tb_eeprom_spi_bridge.sv
// Bench for eeprom_spi_bridge: behavioural 25xx EEPROM on the SPI pins plus frame/response scoreboards.
// Expected frames and responses are queued as each request is issued and matched against what the pins show.
module tb_eeprom_spi_bridge;
  localparam int CLK_DIV  = 1;
  localparam int CS_GAP   = 2;
  localparam int POLL_MAX = 4;
  localparam int RD_LAT   = 1 + 48 * CLK_DIV;

  typedef struct { int bits; logic [23:0] data; int low; int gap; } frame_t;
  typedef struct { int cyc; logic [7:0] rdata; logic err; } rsp_t;
  typedef struct { logic [7:0] rdata; logic err; int lat; } exp_rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sck, spi_cs_n, spi_mosi;
  logic spi_miso = 1'b0;

  eeprom_spi_bridge_if bus();

  eeprom_spi_bridge #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int       tests = 0;
  int       fails = 0;
  frame_t   obs_f[$];
  frame_t   exp_f[$];
  rsp_t     obs_r[$];
  exp_rsp_t exp_r[$];
  int       acc_q[$];
  logic [7:0] mem [256];
  int       wip_polls = 0;
  bit       wip_forever = 1'b0;

  int         cyc = 0, fall_cyc = 0, rise_cyc = 0, gap_len = 0;
  int         m_bits = 0, m_polls = 0, mosi_bad = 0;
  logic [23:0] m_shift = '0;
  logic [7:0]  m_out = '0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0;

  // EEPROM model and pin monitor, sampled on the inactive clock edge
  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !spi_cs_n) begin
      fall_cyc = cyc;
      gap_len  = cyc - rise_cyc;
      m_bits   = 0;
      m_shift  = '0;
      m_out    = '0;
      spi_miso = 1'b0;
    end
    if (!spi_cs_n && !prev_sck && spi_sck) begin
      m_shift = {m_shift[22:0], spi_mosi};
      m_bits++;
    end
    if (!spi_cs_n && prev_sck && !spi_sck) begin
      if (m_bits == 8 && m_shift[7:0] == 8'h05) begin
        m_out = (wip_forever || m_polls < wip_polls) ? 8'h03 : 8'hFE;
        m_polls++;
      end else if (m_bits == 16 && m_shift[15:8] == 8'h03) begin
        m_out = mem[m_shift[7:0]];
      end else begin
        m_out = {m_out[6:0], 1'b0};
      end
      spi_miso = m_out[7];
    end
    if (!prev_cs && spi_cs_n) begin
      obs_f.push_back('{m_bits, m_shift, cyc - fall_cyc, gap_len});
      rise_cyc = cyc;
    end
    if (spi_cs_n === 1'b1 && spi_mosi !== 1'b0) mosi_bad++;
    if (bus.rsp_valid === 1'b1) obs_r.push_back('{cyc, bus.rsp_rdata, bus.rsp_err});
    if (!rst && bus.req_valid && bus.req_ready === 1'b1) begin
      acc_q.push_back(cyc);
      m_polls = 0;
    end
    prev_cs  = spi_cs_n;
    prev_sck = spi_sck;
  end

  task automatic push_frame(input int bits, input logic [23:0] data, input int gap);
    exp_f.push_back('{bits, data, 2 * bits * CLK_DIV, gap});
  endtask

  task automatic clear_all();
    obs_f.delete(); exp_f.delete(); obs_r.delete(); exp_r.delete(); acc_q.delete();
  endtask

  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d, output bit ok);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    for (int i = 0; i < 3000 && obs_r.size() < n; i++) begin
      @(negedge clk); #1;
    end
    ok = (obs_r.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, spi_cs_n, spi_sck, spi_mosi}
        !== {3'b100, 8'h00, 1'b0, 3'b100}) begin
      fails++;
      $display("FAIL reset_values: got rdy/busy/vld=%b%b%b rdata=%h err=%b cs/sck/mosi=%b%b%b required 100 00 0 100",
               bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, spi_cs_n, spi_sck, spi_mosi);
    end
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if ({bus.req_ready, spi_cs_n, spi_sck, spi_mosi} !== 4'b1100) begin
      fails++;
      $display("FAIL idle_pins: got rdy/cs/sck/mosi=%b%b%b%b required 1100", bus.req_ready, spi_cs_n, spi_sck, spi_mosi);
    end
    tests++;
    if (obs_r.size() != 0 || obs_f.size() != 0 || mosi_bad != 0) begin
      fails++;
      $display("FAIL idle_activity: got %0d rsp %0d frames %0d mosi_hi required 0 0 0", obs_r.size(), obs_f.size(), mosi_bad);
    end
  endtask

  task automatic test_read();
    bit ok;
    frame_t ef, of;
    rsp_t r;
    exp_rsp_t e;
    int a;
    clear_all();
    mem[8'h5A] = 8'hC3;
    push_frame(24, 24'h035A00, -1);
    exp_r.push_back('{8'hC3, 1'b0, RD_LAT});
    issue(1'b0, 8'h5A, 8'h00, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL read_accept: got no accept required accept"); end
    wait_rsp(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL read_rsp: got timeout required rsp_valid"); end
    while (exp_f.size() > 0) begin
      ef = exp_f.pop_front();
      tests++;
      if (obs_f.size() == 0) begin
        fails++; $display("FAIL read_frame: got none required data %h", ef.data);
      end else begin
        of = obs_f.pop_front();
        if (of.bits != ef.bits || of.data !== ef.data || of.low != ef.low || (ef.gap >= 0 && of.gap != ef.gap)) begin
          fails++;
          $display("FAIL read_frame: got bits=%0d data=%h low=%0d gap=%0d required bits=%0d data=%h low=%0d gap=%0d",
                   of.bits, of.data, of.low, of.gap, ef.bits, ef.data, ef.low, ef.gap);
        end
      end
    end
    if (obs_r.size() > 0 && acc_q.size() > 0) begin
      r = obs_r.pop_front(); e = exp_r.pop_front(); a = acc_q.pop_front();
      tests++;
      if (r.rdata !== e.rdata || r.err !== e.err) begin
        fails++; $display("FAIL read_data: got rdata=%h err=%b required rdata=%h err=%b", r.rdata, r.err, e.rdata, e.err);
      end
      tests++;
      if (r.cyc - a != e.lat) begin
        fails++; $display("FAIL read_latency: got %0d required %0d", r.cyc - a, e.lat);
      end
    end
  endtask

  task automatic run_write(input string name, input logic [7:0] a, input logic [7:0] d, input bit forever_wip,
                           input int polls, input logic exp_err);
    bit ok;
    frame_t ef, of;
    rsp_t r;
    exp_rsp_t e;
    clear_all();
    wip_forever = forever_wip;
    wip_polls   = polls;
    push_frame(8, 24'h000006, -1);
    push_frame(24, {8'h02, a, d}, CS_GAP);
    for (int i = 0; i < (forever_wip ? POLL_MAX : polls + 1); i++) push_frame(16, 24'h000500, CS_GAP);
    exp_r.push_back('{bus.rsp_rdata, exp_err, -1});
    issue(1'b1, a, d, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_accept: got no accept required accept", name); end
    wait_rsp(1, ok);
    tests++;
    if (!ok || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL %s_rsp: got rsp=%b rdy=%b busy=%b required 1 0 1", name, ok, bus.req_ready, bus.busy);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL %s_ready_return: got rdy=%b vld=%b required 1 0", name, bus.req_ready, bus.rsp_valid);
    end
    repeat (40) @(posedge clk);
    while (exp_f.size() > 0) begin
      ef = exp_f.pop_front();
      tests++;
      if (obs_f.size() == 0) begin
        fails++; $display("FAIL %s_frame: got none required data %h", name, ef.data);
      end else begin
        of = obs_f.pop_front();
        if (of.bits != ef.bits || of.data !== ef.data || of.low != ef.low || (ef.gap >= 0 && of.gap != ef.gap)) begin
          fails++;
          $display("FAIL %s_frame: got bits=%0d data=%h low=%0d gap=%0d required bits=%0d data=%h low=%0d gap=%0d",
                   name, of.bits, of.data, of.low, of.gap, ef.bits, ef.data, ef.low, ef.gap);
        end
      end
    end
    tests++;
    if (obs_f.size() != 0) begin fails++; $display("FAIL %s_extra_frames: got %0d required 0", name, obs_f.size()); end
    tests++;
    if (obs_r.size() != 1) begin
      fails++; $display("FAIL %s_rsp_count: got %0d required 1", name, obs_r.size());
    end else begin
      r = obs_r.pop_front(); e = exp_r.pop_front();
      tests++;
      if (r.rdata !== e.rdata || r.err !== e.err) begin
        fails++; $display("FAIL %s_rsp: got rdata=%h err=%b required rdata=%h err=%b", name, r.rdata, r.err, e.rdata, e.err);
      end
    end
    tests++;
    if (mosi_bad != 0) begin fails++; $display("FAIL %s_mosi_idle: got %0d high samples required 0", name, mosi_bad); end
  endtask

  task automatic test_write();
    run_write("write", 8'h10, 8'hA5, 1'b0, 3, 1'b0);
  endtask

  task automatic test_timeout();
    run_write("timeout", 8'h20, 8'h3C, 1'b1, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    frame_t of;
    rsp_t r;
    int a;
    clear_all();
    mem[8'h81] = 8'h77;
    mem[8'h42] = 8'h9E;
    issue(1'b0, 8'h81, 8'h00, ok);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({spi_cs_n, spi_sck, spi_mosi, bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_rdata} !== {6'b100100, 8'h00}) begin
      fails++;
      $display("FAIL reset_mid_pins: got cs/sck/mosi/rdy/busy/vld=%b%b%b%b%b%b rdata=%h required 100100 00",
               spi_cs_n, spi_sck, spi_mosi, bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_rdata);
    end
    rst = 1'b0;
    repeat (10) @(posedge clk);
    tests++;
    if (obs_r.size() != 0) begin fails++; $display("FAIL reset_mid_no_rsp: got %0d rsp required 0", obs_r.size()); end
    clear_all();
    issue(1'b0, 8'h42, 8'h00, ok);
    wait_rsp(1, ok);
    repeat (5) @(posedge clk);
    tests++;
    if (!ok || obs_f.size() != 1 || acc_q.size() != 1) begin
      fails++; $display("FAIL reset_mid_reread: got rsp=%b frames=%0d accepts=%0d required 1 1 1", ok, obs_f.size(), acc_q.size());
    end else begin
      of = obs_f.pop_front(); r = obs_r.pop_front(); a = acc_q.pop_front();
      tests++;
      if (of.data !== 24'h034200 || r.rdata !== 8'h9E || r.err !== 1'b0 || r.cyc - a != RD_LAT) begin
        fails++;
        $display("FAIL reset_mid_reread_data: got frame=%h rdata=%h err=%b lat=%0d required 034200 9e 0 %0d",
                 of.data, r.rdata, r.err, r.cyc - a, RD_LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_all();
    mem[8'h00] = 8'h11;
    mem[8'hFF] = 8'hEE;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h00;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_addr = 8'hFF;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_rsp(2, ok);
    repeat (5) @(posedge clk);
    tests++;
    if (!ok || acc_q.size() != 2 || obs_f.size() != 2) begin
      fails++; $display("FAIL b2b_counts: got rsp=%0d accepts=%0d frames=%0d required 2 2 2", obs_r.size(), acc_q.size(), obs_f.size());
    end else begin
      tests++;
      if (acc_q[1] != obs_r[0].cyc + 1) begin
        fails++; $display("FAIL b2b_accept_cycle: got %0d required %0d", acc_q[1], obs_r[0].cyc + 1);
      end
      tests++;
      if (obs_f[1].gap < CS_GAP) begin
        fails++; $display("FAIL b2b_cs_gap: got %0d required >= %0d", obs_f[1].gap, CS_GAP);
      end
      tests++;
      if (obs_f[0].data !== 24'h030000 || obs_f[1].data !== 24'h03FF00) begin
        fails++; $display("FAIL b2b_frames: got %h %h required 030000 03ff00", obs_f[0].data, obs_f[1].data);
      end
      tests++;
      if (obs_r[0].rdata !== 8'h11 || obs_r[1].rdata !== 8'hEE || obs_r[1].cyc - acc_q[1] != RD_LAT) begin
        fails++;
        $display("FAIL b2b_rdata: got %h %h lat=%0d required 11 ee %0d", obs_r[0].rdata, obs_r[1].rdata,
                 obs_r[1].cyc - acc_q[1], RD_LAT);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/eeprom_spi_bridge.md
Name: eeprom_spi_bridge

Overview:
- Sits directly downstream of the uC_8bits memory port.
- Converts single-byte read/write requests from the core into SPI transactions to an external 25xx-style serial EEPROM with an 8-bit address.
- Handles write-enable latching and write-in-progress polling.
- Stalls the core through a ready/valid handshake until each access completes.

Parameters:
- CLK_DIV, 4, SCK half-period in clk cycles; legal range 1..255.
- CS_GAP, 2, minimum clk cycles spi_cs_n stays high between frames; legal range >=1.
- POLL_MAX, 1023, maximum RDSR polls after a WRITE before the access is flagged as an error.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core requests an access.
- req_ready  output  1  bridge can accept a request; high only in IDLE.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  8  EEPROM byte address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle pulse when an access completes.
- rsp_rdata  output  8  read data; holds until the next read completes.
- rsp_err  output  1  valid with rsp_valid; 1 = write poll timeout.
- busy  output  1  high from request accept through the rsp_valid cycle.
- spi_sck  output  1  SPI clock, mode 0, idles low.
- spi_cs_n  output  1  chip select, active low.
- spi_mosi  output  1  serial data out, MSB first.
- spi_miso  input  1  serial data in.

Behaviour:
- Reset values:
  - req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00, rsp_err=0
  - spi_cs_n=1, spi_sck=0, spi_mosi=0
  - FSM=IDLE, all counters 0
- Reset mid-transfer:
  - All of the above values are applied on the next clk edge.
  - cs_n rises immediately; no rsp_valid is produced; the aborted access is discarded.
- Handshake:
  - A request is accepted on a cycle where req_valid && req_ready.
  - req_we, req_addr and req_wdata are captured that cycle.
  - req_ready drops the following cycle and returns to 1 the cycle after rsp_valid.
- Opcodes: WREN 0x06, WRITE 0x02, READ 0x03, RDSR 0x05.
- Frame timing:
  - cs_n falls with bit 0 already on mosi and sck low.
  - Every CLK_DIV cycles sck toggles.
  - miso is sampled on the cycle sck rises.
  - mosi is updated on the cycle sck falls.
  - After the last bit's falling edge, cs_n rises on that same cycle.
  - Frame of N bits: cs_n is low for exactly 2*N*CLK_DIV cycles.
  - mosi is driven 0 while cs_n is high.
  - Between two frames cs_n is high for exactly CS_GAP cycles.
- FSM states: IDLE, WREN, GAP, XFER, POLL, RESP.
  - IDLE: accept a request. Read goes to XFER. Write goes to WREN.
  - WREN: sends the 8-bit frame 0x06, then GAP, then XFER.
  - XFER, read: 24-bit frame of 0x03, addr, then 8 don't-care bits on mosi (0). The last 8 sampled miso bits are loaded into rsp_rdata. Then RESP.
  - XFER, write: 24-bit frame of 0x02, addr, wdata. Then GAP, then POLL.
  - POLL: 16-bit frame of 0x05 plus a status byte. Bit 0 of the status byte is WIP.
    - WIP=0: go to RESP with err=0.
    - WIP=1 and poll count < POLL_MAX: GAP, then POLL again.
    - WIP=1 on poll number POLL_MAX: go to RESP with err=1.
  - RESP: rsp_valid=1 for one cycle; then IDLE.
    - rsp_valid is the first cycle after the final cs_n rise.
    - rsp_err is 0 for reads. rsp_rdata is unchanged on writes.
- Poll counter: 10 bits wide; cleared on every accept.
- Latency, read: accept at cycle 0, cs_n low from cycle 1, rsp_valid at cycle 1 + 48*CLK_DIV.
- req_valid asserted while busy is ignored; it is not queued.
- Write and read to the same address are fully serialized; no ordering hazards exist inside the block.

Test Plan:
- Reset, then idle 10 cycles -> req_ready=1, cs_n=1, sck=0, mosi=0, rsp_valid never 1.
- CLK_DIV=1, read addr 0x5A, model returns 0xC3 -> mosi stream 0x03,0x5A; cs_n low 48 cycles; rsp_valid at cycle 49 with rsp_rdata=0xC3, rsp_err=0.
- Write addr 0x10 data 0xA5, model reports WIP=1 for 3 polls then 0 -> frames in order 0x06 | 0x02,0x10,0xA5 | 4x RDSR; each inter-frame gap is exactly CS_GAP cycles; one rsp_valid with err=0.
- POLL_MAX=4, model holds WIP=1 forever -> exactly 4 RDSR frames, then rsp_valid with rsp_err=1; req_ready returns to 1 on the next cycle.
- Assert rst during the addr byte of a read -> cs_n=1 and sck=0 on the next cycle; no rsp_valid; a new read issued afterwards completes correctly.
- Hold req_valid high with back-to-back reads 0x00 then 0xFF -> the second request is accepted only the cycle after the first rsp_valid; the second frame's cs_n fall comes at least CS_GAP cycles after the first frame's cs_n rise.
